if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 173 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage feeding the IF/ID register. It owns the program
// counter, talks to a variable-latency instruction memory over a req/ack
// handshake, honours the freeze coming back from decode, and handles
// taken-branch redirects, including redirects that land while a fetch is
// still in flight.
//
// Ports
//    clk          system clock, rising edge
//    rst          asynchronous active-high reset
//    freeze       hazard stall from decode; holds outputs and PC
//    Br_taken     taken-branch redirect from execute
//    Br_Addr      branch target (low two bits are dropped)
//    imem_req     fetch request to instruction memory
//    imem_addr    fetch address, stable until the ack arrives
//    imem_ack     memory data valid this cycle (may share the req cycle)
//    imem_rdata   instruction word from memory
//    PC           PC+4 of the instruction currently on Instruction
//    Instruction  fetched instruction towards decode
//    IF_valid     Instruction/PC carry a real instruction
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        Br_taken,
   input  logic [31:0] Br_Addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] Instruction,
   output logic        IF_valid
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetchState_t;

   fetchState_t r_state, w_nextState;

   logic [31:0] r_pc, w_nextPc;
   logic [31:0] r_abandonAddr, w_nextAbandonAddr;
   logic [31:0] r_bufInstr, w_nextBufInstr;
   logic [31:0] r_bufPc, w_nextBufPc;
   logic [31:0] r_outPc, w_nextOutPc;
   logic [31:0] r_outInstr, w_nextOutInstr;
   logic        r_outValid, w_nextOutValid;

   logic [31:0] w_target;
   logic [31:0] w_pcPlus4;

   // Branch targets are always word aligned; the increment wraps mod 2^32.
   assign w_target  = Br_Addr & ~32'd3;
   assign w_pcPlus4 = r_pc + 32'd4;

   // The memory sees a request whenever we are not parked on a buffered
   // word. While draining an abandoned fetch, the old address must stay on
   // the bus until the memory acknowledges it, even though r_pc has already
   // moved to the branch target.
   assign imem_req    = (r_state != HOLD);
   assign imem_addr   = (r_state == DISCARD) ? r_abandonAddr : r_pc;
   assign PC          = r_outPc;
   assign Instruction = r_outInstr;
   assign IF_valid    = r_outValid;

   // State and datapath registers. Everything returns to its reset value
   // immediately on rst, including an outstanding fetch, which is simply
   // forgotten because the memory is reset by the same signal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= FETCH;
         r_pc          <= RESET_PC;
         r_abandonAddr <= RESET_PC;
         r_bufInstr    <= NOP_INSTR;
         r_bufPc       <= 32'd0;
         r_outPc       <= 32'd0;
         r_outInstr    <= NOP_INSTR;
         r_outValid    <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         r_pc          <= w_nextPc;
         r_abandonAddr <= w_nextAbandonAddr;
         r_bufInstr    <= w_nextBufInstr;
         r_bufPc       <= w_nextBufPc;
         r_outPc       <= w_nextOutPc;
         r_outInstr    <= w_nextOutInstr;
         r_outValid    <= w_nextOutValid;
      end
   end

   // Next-state and datapath logic. A taken branch always wins over freeze
   // and flushes the outputs to a bubble. A word that returns while decode
   // is frozen is parked in the hold buffer so it is neither lost nor shown
   // twice. A redirect that arrives before the ack sends us to DISCARD so
   // the stale word can be swallowed when it finally returns.
   always_comb begin
      w_nextState       = r_state;
      w_nextPc          = r_pc;
      w_nextAbandonAddr = r_abandonAddr;
      w_nextBufInstr    = r_bufInstr;
      w_nextBufPc       = r_bufPc;
      w_nextOutPc       = r_outPc;
      w_nextOutInstr    = r_outInstr;
      w_nextOutValid    = r_outValid;

      unique case (r_state)
         FETCH: begin
            if (Br_taken) begin
               w_nextPc       = w_target;
               w_nextOutInstr = NOP_INSTR;
               w_nextOutValid = 1'b0;
               if (!imem_ack) begin
                  w_nextAbandonAddr = r_pc;
                  w_nextState       = DISCARD;
               end
            end else if (imem_ack) begin
               w_nextPc = w_pcPlus4;
               if (!freeze) begin
                  w_nextOutInstr = imem_rdata;
                  w_nextOutPc    = w_pcPlus4;
                  w_nextOutValid = 1'b1;
               end else begin
                  w_nextBufInstr = imem_rdata;
                  w_nextBufPc    = w_pcPlus4;
                  w_nextState    = HOLD;
               end
            end else if (!freeze) begin
               w_nextOutInstr = NOP_INSTR;
               w_nextOutValid = 1'b0;
            end
         end

         HOLD: begin
            if (Br_taken) begin
               w_nextPc       = w_target;
               w_nextOutInstr = NOP_INSTR;
               w_nextOutValid = 1'b0;
               w_nextState    = FETCH;
            end else if (!freeze) begin
               w_nextOutInstr = r_bufInstr;
               w_nextOutPc    = r_bufPc;
               w_nextOutValid = 1'b1;
               w_nextState    = FETCH;
            end
         end

         DISCARD: begin
            if (Br_taken) begin
               w_nextPc       = w_target;
               w_nextOutInstr = NOP_INSTR;
               w_nextOutValid = 1'b0;
            end
            if (imem_ack) begin
               w_nextState = FETCH;
            end
         end

         default: begin
            w_nextState = FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Drives the fetch stage against a behavioural instruction memory whose
// latency is drawn per transaction, and compares every cycle against a
// reference model kept as plain flags and words: the next address to
// fetch, whether a fetch was abandoned by a redirect, and whether a word is
// parked for a frozen decode stage.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        Br_taken;
   logic [31:0] Br_Addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        IF_valid;

   int compared;
   int mismatched;

   int minLat;
   int maxLat;
   int memLat;
   int waitCnt;

   logic [31:0] mPc;
   logic        mAbandoned;
   logic [31:0] mAbandonAddr;
   logic        mBufFull;
   logic [31:0] mBufInstr;
   logic [31:0] mBufPc;
   logic [31:0] mOutPc;
   logic [31:0] mOutInstr;
   logic        mOutValid;

   logic [97:0] gotVec;
   logic [97:0] expVec;

   if_fetch_stage #(
      .RESET_PC (RST_PC),
      .NOP_INSTR(NOP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .freeze     (freeze),
      .Br_taken   (Br_taken),
      .Br_Addr    (Br_Addr),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .PC         (PC),
      .Instruction(Instruction),
      .IF_valid   (IF_valid)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory content: word at byte address a is (a/4)+1.
   function automatic logic [31:0] romWord(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   assign imem_rdata = romWord(imem_addr);
   assign imem_ack   = imem_req && (waitCnt == memLat - 1);

   // Memory handshake: acknowledges after memLat cycles of request (1 means
   // in the request cycle) and draws a fresh latency for the next fetch.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         waitCnt <= 0;
         memLat  <= int'($urandom_range(maxLat, minLat));
      end else if (imem_req) begin
         if (imem_ack) begin
            waitCnt <= 0;
            memLat  <= int'($urandom_range(maxLat, minLat));
         end else begin
            waitCnt <= waitCnt + 1;
         end
      end
   end

   // Reference model expectations for the memory-side outputs.
   function automatic logic expReq();
      return !mBufFull;
   endfunction

   function automatic logic [31:0] expAddr();
      return mAbandoned ? mAbandonAddr : mPc;
   endfunction

   // Reference model reset.
   task automatic modelReset();
      mPc          = RST_PC;
      mAbandoned   = 1'b0;
      mAbandonAddr = RST_PC;
      mBufFull     = 1'b0;
      mBufInstr    = NOP;
      mBufPc       = 32'd0;
      mOutPc       = 32'd0;
      mOutInstr    = NOP;
      mOutValid    = 1'b0;
   endtask

   // One clock of the reference model: redirect first, then freeze.
   task automatic modelStep(input logic ack, input logic fr, input logic br,
                            input logic [31:0] ba);
      logic [31:0] tgt;
      tgt = {ba[31:2], 2'b00};
      if (br) begin
         mOutInstr = NOP;
         mOutValid = 1'b0;
      end
      if (mBufFull) begin
         if (br) begin
            mBufFull = 1'b0;
            mPc      = tgt;
         end else if (!fr) begin
            mOutInstr = mBufInstr;
            mOutPc    = mBufPc;
            mOutValid = 1'b1;
            mBufFull  = 1'b0;
         end
      end else if (mAbandoned) begin
         if (br) mPc = tgt;
         if (ack) mAbandoned = 1'b0;
      end else if (br) begin
         if (!ack) begin
            mAbandoned   = 1'b1;
            mAbandonAddr = mPc;
         end
         mPc = tgt;
      end else if (ack) begin
         if (!fr) begin
            mOutInstr = romWord(mPc);
            mOutPc    = mPc + 32'd4;
            mOutValid = 1'b1;
         end else begin
            mBufInstr = romWord(mPc);
            mBufPc    = mPc + 32'd4;
            mBufFull  = 1'b1;
         end
         mPc = mPc + 32'd4;
      end else if (!fr) begin
         mOutInstr = NOP;
         mOutValid = 1'b0;
      end
   endtask

   // Drives one cycle of inputs at the falling edge, advances the model
   // across the rising edge, and returns 1 unit after that edge.
   task automatic applyStimulus(input logic fr, input logic br,
                                input logic [31:0] ba);
      logic ack;
      @(negedge clk);
      freeze   = fr;
      Br_taken = br;
      Br_Addr  = ba;
      #1;
      ack = expReq() && (waitCnt == memLat - 1);
      modelStep(ack, fr, br, ba);
      @(posedge clk);
      #1;
   endtask

   task automatic assertReset(input int lo, input int hi);
      minLat   = lo;
      maxLat   = hi;
      freeze   = 1'b0;
      Br_taken = 1'b0;
      Br_Addr  = 32'd0;
      #2;
      rst = 1'b1;
      modelReset();
   endtask

   task automatic releaseReset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Packs observed and modelled outputs into one word each.
   task automatic sampleVectors();
      gotVec = {IF_valid, Instruction, PC, imem_req, imem_addr};
      expVec = {mOutValid, mOutInstr, mOutPc, expReq(), expAddr()};
   endtask

   task automatic test_reset();
      assertReset(1, 1);
      #1;
      gotVec = {IF_valid, Instruction, PC, imem_req, imem_addr};
      expVec = {1'b0, NOP, 32'd0, 1'b1, RST_PC};
      compared++;
      if (gotVec !== expVec) begin
         mismatched++;
         $display("[TB] FAIL reset_values got=%h want=%h", gotVec, expVec);
      end
      releaseReset();
   endtask

   task automatic test_zero_wait();
      assertReset(1, 1);
      releaseReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         sampleVectors();
         compared++;
         if (gotVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL zero_wait_model cyc=%0d got=%h want=%h", i, gotVec, expVec);
         end
         compared++;
         if ({IF_valid, Instruction, PC} !== {1'b1, (RST_PC >> 2) + 32'd1 + 32'(i), RST_PC + 32'd4 + 32'(4 * i)}) begin
            mismatched++;
            $display("[TB] FAIL zero_wait_stream cyc=%0d got=%b/%h/%h", i, IF_valid, Instruction, PC);
         end
      end
   endtask

   task automatic test_latency3();
      int validCycles;
      validCycles = 0;
      assertReset(3, 3);
      releaseReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         sampleVectors();
         if (IF_valid === 1'b1) validCycles++;
         compared++;
         if (gotVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL latency3 cyc=%0d got=%h want=%h", i, gotVec, expVec);
         end
      end
      compared++;
      if (validCycles !== 3) begin
         mismatched++;
         $display("[TB] FAIL latency3_valid_count got=%0d want=3", validCycles);
      end
   endtask

   task automatic test_freeze_hold();
      assertReset(2, 2);
      releaseReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus((i >= 1 && i <= 4), 1'b0, 32'd0);
         sampleVectors();
         compared++;
         if (gotVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL freeze_hold cyc=%0d got=%h want=%h", i, gotVec, expVec);
         end
         if (i == 5) begin
            compared++;
            if ({IF_valid, Instruction, PC} !== {1'b1, 32'h41, 32'h104}) begin
               mismatched++;
               $display("[TB] FAIL freeze_unload got=%b/%h/%h want=1/41/104", IF_valid, Instruction, PC);
            end
         end
      end
   endtask

   task automatic test_branch_outstanding();
      assertReset(3, 3);
      releaseReset();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, (i == 6), 32'h0000_0043);
         sampleVectors();
         compared++;
         if (gotVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL branch_model cyc=%0d got=%h want=%h", i, gotVec, expVec);
         end
         if (i == 6 || i == 7) begin
            compared++;
            if ({IF_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h108}) begin
               mismatched++;
               $display("[TB] FAIL branch_old_addr cyc=%0d got=%b/%b/%h", i, IF_valid, imem_req, imem_addr);
            end
         end
         if (i == 8) begin
            compared++;
            if ({IF_valid, imem_addr} !== {1'b0, 32'h40}) begin
               mismatched++;
               $display("[TB] FAIL branch_target_req got=%b/%h want=0/40", IF_valid, imem_addr);
            end
         end
         if (i == 11) begin
            compared++;
            if ({IF_valid, Instruction, PC} !== {1'b1, 32'h11, 32'h44}) begin
               mismatched++;
               $display("[TB] FAIL branch_first_instr got=%b/%h/%h want=1/11/44", IF_valid, Instruction, PC);
            end
         end
      end
   endtask

   task automatic test_branch_freeze_hold();
      assertReset(1, 1);
      releaseReset();
      applyStimulus(1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0200);
      sampleVectors();
      compared++;
      if ({IF_valid, Instruction, imem_addr} !== {1'b0, NOP, 32'h200} || gotVec !== expVec) begin
         mismatched++;
         $display("[TB] FAIL br_freeze_flush got=%h want=%h", gotVec, expVec);
      end
      applyStimulus(1'b0, 1'b0, 32'd0);
      compared++;
      if ({IF_valid, Instruction, PC} !== {1'b1, 32'h81, 32'h204}) begin
         mismatched++;
         $display("[TB] FAIL br_freeze_resume got=%b/%h/%h want=1/81/204", IF_valid, Instruction, PC);
      end
   endtask

   task automatic test_wrap();
      assertReset(1, 1);
      releaseReset();
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
      applyStimulus(1'b0, 1'b0, 32'd0);
      compared++;
      if ({IF_valid, Instruction, PC, imem_addr} !== {1'b1, 32'h4000_0000, 32'd0, 32'd0}) begin
         mismatched++;
         $display("[TB] FAIL pc_wrap got=%b/%h/%h/%h", IF_valid, Instruction, PC, imem_addr);
      end
      applyStimulus(1'b0, 1'b0, 32'd0);
      compared++;
      if ({IF_valid, Instruction, PC} !== {1'b1, 32'h1, 32'h4}) begin
         mismatched++;
         $display("[TB] FAIL pc_after_wrap got=%b/%h/%h want=1/1/4", IF_valid, Instruction, PC);
      end
   endtask

   task automatic test_reset_mid_wait();
      assertReset(3, 3);
      releaseReset();
      applyStimulus(1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0800);
      assertReset(3, 3);
      #1;
      compared++;
      if ({IF_valid, Instruction, PC, imem_req, imem_addr} !== {1'b0, NOP, 32'd0, 1'b1, RST_PC}) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_wait got=%b/%h/%h/%b/%h", IF_valid, Instruction, PC, imem_req, imem_addr);
      end
      releaseReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         sampleVectors();
         compared++;
         if (gotVec !== expVec || (i == 0 && imem_addr !== RST_PC)) begin
            mismatched++;
            $display("[TB] FAIL reset_resume cyc=%0d got=%h want=%h", i, gotVec, expVec);
         end
      end
   endtask

   task automatic test_random();
      logic fr;
      logic br;
      assertReset(1, 4);
      releaseReset();
      for (int i = 0; i < 400; i++) begin
         fr = ($urandom_range(9, 0) < 3);
         br = ($urandom_range(15, 0) == 0);
         applyStimulus(fr, br, $urandom);
         sampleVectors();
         compared++;
         if (gotVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL random cyc=%0d got=%h want=%h", i, gotVec, expVec);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b0;
      freeze     = 1'b0;
      Br_taken   = 1'b0;
      Br_Addr    = 32'd0;
      minLat     = 1;
      maxLat     = 1;
      modelReset();
      @(posedge clk);
      #1;
      test_reset();
      test_zero_wait();
      test_latency3();
      test_freeze_hold();
      test_branch_outstanding();
      test_branch_freeze_hold();
      test_wrap();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
